alu_operand_sequencer: RTL and testbench
========================================

// Module: alu_operand_sequencer
// PURPOSE
//  Front/back-end stage around the ALU's 16-bit bitwise logic units (XNOR, AND, OR, ...).
//  Assembles operands A and B from a byte-wide input stream and presents them, stable, to the logic unit.
//  Samples the unit's combinational result Y after a settle window and returns it over a valid/ready output.
//  One operation is in flight at a time: load A, load B, evaluate, hand off the result.
// PARAMETERS
//  WIDTH        16  operand/result width in bits; must be a multiple of 8
//  EVAL_CYCLES  1   settle cycles between driving op_a/op_b and sampling op_y; range 1..15
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      in_byte carries valid data
//  in_ready   out  1      block accepts a byte this cycle
//  in_byte    in   8      operand byte, least significant byte first
//  op_a       out  WIDTH  operand A to logic unit (registered)
//  op_b       out  WIDTH  operand B to logic unit (registered)
//  op_y       in   WIDTH  combinational result from logic unit
//  res_valid  out  1      res_data is valid
//  res_ready  in   1      consumer accepts the result
//  res_data   out  WIDTH  captured result
//  busy       out  1      high from first accepted byte until result handshake
// BEHAVIOUR
//  Clock and reset: one clock, clk. rst is asynchronous and active-high.
//  Reset values: op_a=0, op_b=0, res_data=0, res_valid=0, busy=0.
//   While rst is high, in_ready=0. The FSM enters LOAD_A with byte index 0.
//  FSM states: LOAD_A -> LOAD_B -> EVAL -> HOLD -> LOAD_A.
//  Handshake: a byte is accepted on an edge where in_valid && in_ready. in_ready=1 only in LOAD_A/LOAD_B.
//  LOAD_A: bytes fill shadow register sa[8*i+:8], i=0..N-1 (N=WIDTH/8).
//   After byte N-1 the FSM goes to LOAD_B and i clears.
//  LOAD_B: bytes fill shadow register sb in the same way.
//   On the edge that accepts byte N-1: op_a<=sa, op_b<=sb, counter<=EVAL_CYCLES, FSM goes to EVAL.
//  op_a/op_b change only on that commit edge, so the logic unit never sees partial operands.
//   They hold their values until the next commit.
//  EVAL: the counter decrements each edge. On the edge where counter==1: res_data<=op_y, res_valid<=1, FSM goes to HOLD.
//   Latency: last B byte accepted at edge k -> res_valid high after edge k+EVAL_CYCLES.
//  HOLD: res_valid and res_data stay stable while res_ready=0 (full backpressure, no timeout).
//   On the edge with res_valid && res_ready: res_valid<=0, busy<=0, FSM goes to LOAD_A.
//   in_ready rises in the next cycle; there is no same-cycle turnaround.
//  busy is set on the first accepted A byte and cleared on the result handshake.
//  in_valid while in_ready=0 is ignored; the byte is not stored.
//  in_valid gaps while loading: the byte index holds and no state changes.
//  Reset mid-operation: all partial bytes and any pending result are discarded; outputs return to reset values.
//  op_y is not registered inside the block except at capture; the logic unit must settle within EVAL_CYCLES clocks.
// CONFIGURATION
//  RESULT_PARITY_EN defined:
//   Adds output res_parity (1 bit) = ^op_y, registered on the same edge as res_data.
//   Reset value 0; held with res_data during HOLD.
//  RESULT_PARITY_EN undefined: res_parity port and logic are absent; all other behaviour is identical.
// TESTING
//  Basic XNOR: bytes AA,AA,55,55 with a 16-bit XNOR on op_y -> op_a=AAAA, op_b=5555;
//   res_data=0000 one cycle after commit; parity=0.
//  Gapped input: bytes 34,12,21,43 with in_valid low 2 cycles between each -> op_a=1234, op_b=4321;
//   XNOR res_data=AEEA.
//  Backpressure: res_ready=0 for 5 cycles after res_valid -> res_data held, in_ready=0, extra in_valid bytes ignored.
//   Next op F0F0/F0F0 -> FFFF.
//  EVAL_CYCLES=3: last B byte at edge k -> res_valid first high after edge k+3.
//   op_a/op_b stable for the whole window.
//  Reset mid-load: rst pulsed after 3 bytes (0F,0F,F0) -> all outputs 0.
//   A fresh 0F,0F,F0,F0 yields op_a=0F0F, op_b=F0F0, XNOR result 0000.
//  Back-to-back ops: FFFF/FFFF then 3C3C/C3C3 with res_ready=1 -> results FFFF then 0000.
//   busy falls exactly at each handshake.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// Byte-stream operand assembler and result sampler wrapped around a combinational ALU logic unit.
// Optional RESULT_PARITY_EN adds a registered even-parity bit alongside res_data.
module alu_operand_sequencer #(
    parameter int WIDTH       = 16,
    parameter int EVAL_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_byte,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] op_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy
`ifdef RESULT_PARITY_EN
    ,
    output logic             res_parity
`endif
);

    localparam int N     = WIDTH / 8;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        EVAL,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sb_nxt;
    logic [3:0]       cnt;
    logic             accept;
    logic             last_byte;
    logic             res_hs;

    assign in_ready  = (state == LOAD_A || state == LOAD_B) && !rst;
    assign accept    = in_valid && in_ready;
    assign last_byte = (idx == IDX_W'(N - 1));
    assign res_hs    = res_valid && res_ready;

    // op_b must include the byte arriving on the commit edge itself.
    always_comb begin
        sb_nxt = sb;
        sb_nxt[8*idx +: 8] = in_byte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD_A;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD_A:  if (accept && last_byte) state_nxt = LOAD_B;
            LOAD_B:  if (accept && last_byte) state_nxt = EVAL;
            EVAL:    if (cnt == 4'd1)         state_nxt = HOLD;
            HOLD:    if (res_hs)              state_nxt = LOAD_A;
            default:                          state_nxt = LOAD_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            sa        <= '0;
            sb        <= '0;
            op_a      <= '0;
            op_b      <= '0;
            cnt       <= '0;
            res_data  <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef RESULT_PARITY_EN
            res_parity <= 1'b0;
`endif
        end else begin
            if (accept) begin
                idx <= last_byte ? '0 : idx + IDX_W'(1);
                if (state == LOAD_A) begin
                    sa[8*idx +: 8] <= in_byte;
                    if (idx == '0) busy <= 1'b1;
                end else begin
                    sb <= sb_nxt;
                    if (last_byte) begin
                        op_a <= sa;
                        op_b <= sb_nxt;
                        cnt  <= 4'(EVAL_CYCLES);
                    end
                end
            end
            if (state == EVAL) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    res_data  <= op_y;
                    res_valid <= 1'b1;
`ifdef RESULT_PARITY_EN
                    res_parity <= ^op_y;
`endif
                end
            end
            if (res_hs) begin
                res_valid <= 1'b0;
                busy      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Randomized scoreboard bench for alu_operand_sequencer driving a 16-bit XNOR logic unit.
// Expected operands/results are queued per operation; a monitor pops them at each result handshake.
module tb_alu_operand_sequencer;

    localparam int W   = 16;
    localparam int N   = W / 8;
    localparam int EVC = 3;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_byte;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] op_y;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         busy;
`ifdef RESULT_PARITY_EN
    logic         res_parity;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    bit   post_hs  = 1'b0;

    always #5 clk = ~clk;

    assign op_y = ~(op_a ^ op_b);

    alu_operand_sequencer #(.WIDTH(W), .EVAL_CYCLES(EVC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_y      (op_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
`ifdef RESULT_PARITY_EN
        ,
        .res_parity(res_parity)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected entry per result handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (post_hs) begin
                check("busy_after_hs", busy, 0);
                check("valid_after_hs", res_valid, 0);
                check("in_ready_after_hs", in_ready, 1);
                post_hs = 1'b0;
            end
            if (res_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else if (res_ready) begin
                    e = sb_q.pop_front();
                    check("res_data", res_data, e.y);
                    check("op_a_at_hs", op_a, e.a);
                    check("op_b_at_hs", op_b, e.b);
                    check("busy_at_hs", busy, 1);
`ifdef RESULT_PARITY_EN
                    check("res_parity", res_parity, ^e.y);
`endif
                    post_hs = 1'b1;
                end else begin
                    check("res_data_held", res_data, sb_q[0].y);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int   n   = 0;
        logic acc = 1'b0;
        in_byte  = b;
        in_valid = 1'b1;
        while (!acc && n < 50) begin
            acc = in_ready;
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (!acc) check("byte_accept_timeout", 0, 1);
    endtask

    task automatic check_reset_values();
        check("rst_op_a", op_a, 0);
        check("rst_op_b", op_b, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
`ifdef RESULT_PARITY_EN
        check("rst_res_parity", res_parity, 0);
`endif
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int gap, input int hold, input bit junk);
        exp_t e;
        int   lat;
        int   n;
        e.a = a;
        e.b = b;
        e.y = ~(a ^ b);
        sb_q.push_back(e);
        res_ready = (hold == 0);
        check("busy_idle", busy, 0);
        for (int i = 0; i < 2 * N; i++) begin
            send_byte(i < N ? a[8*i +: 8] : b[8*(i-N) +: 8]);
            if (i == 0) check("busy_first_byte", busy, 1);
            if (i != 2 * N - 1) repeat (gap) @(negedge clk);
        end
        lat = 0;
        while (!res_valid && lat < 40) begin
            check("op_a_window", op_a, a);
            check("op_b_window", op_b, b);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, EVC);
        if (hold > 0) begin
            in_valid = junk;
            repeat (hold) begin
                in_byte = 8'($urandom);
                @(negedge clk);
                check("in_ready_hold", in_ready, 0);
                check("valid_hold", res_valid, 1);
            end
            in_valid  = 1'b0;
            res_ready = 1'b1;
        end
        n = 0;
        while (res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("handshake_timeout", res_valid, 0);
        res_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);

        do_op(16'hAAAA, 16'h5555, 0, 0, 1'b0);
        do_op(16'h1234, 16'h4321, 2, 0, 1'b0);
        do_op(16'h5A5A, 16'h0FF0, 0, 5, 1'b1);
        do_op(16'hF0F0, 16'hF0F0, 0, 0, 1'b0);

        send_byte(8'h0F);
        send_byte(8'h0F);
        send_byte(8'hF0);
        check("busy_mid_load", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        @(negedge clk);
        do_op(16'h0F0F, 16'hF0F0, 0, 0, 1'b0);

        do_op(16'hFFFF, 16'hFFFF, 0, 0, 1'b0);
        do_op(16'h3C3C, 16'hC3C3, 0, 0, 1'b0);

        for (int t = 0; t < 20; t++) begin
            do_op(W'($urandom), W'($urandom), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 3)), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
